// File: rtl/peripheral_enable_sequencer.sv
// peripheral_enable_sequencer: powers a group of peripherals up in index order and down in reverse,
// waiting for each enable acknowledge plus a settle time, with a sticky fault on handshake timeout.
// Ports:
//   clock, async_resetn  rising-edge clock, asynchronous active-low reset
//   request              level demand for the whole peripheral group
//   enable_req/ack       per-peripheral enable request (thermometer from bit 0) and acknowledge
//   ready/silent         group fully up and settled / group fully off and acknowledged off
//   starting/stopping    power-up / power-down sequence in progress
//   fault, fault_index   sticky handshake timeout and the peripheral it happened on
//   fault_clear          pulse that leaves FAULT once every acknowledge has dropped
module peripheral_enable_sequencer #(
    parameter int NUM_PERIPH    = 4,
    parameter int SETTLE_CYCLES = 2,
    parameter int ACK_TIMEOUT   = 255
) (
    input  logic                  clock,
    input  logic                  async_resetn,
    input  logic                  request,
    output logic [NUM_PERIPH-1:0] enable_req,
    input  logic [NUM_PERIPH-1:0] enable_ack,
    output logic                  ready,
    output logic                  silent,
    output logic                  starting,
    output logic                  stopping,
    output logic                  fault,
    output logic [2:0]            fault_index,
    input  logic                  fault_clear
);
    typedef enum logic [2:0] {
        IDLE, START_STEP, START_SETTLE, READY, STOP_STEP, STOP_SETTLE, FAULT
    } state_t;

    localparam logic [NUM_PERIPH-1:0] ONE = {{(NUM_PERIPH-1){1'b0}}, 1'b1};
    localparam logic [2:0] LAST    = 3'(NUM_PERIPH - 1);
    localparam logic [7:0] SET_END = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] TO_END  = 8'(ACK_TIMEOUT - 1);

    state_t                state_q, state_d;
    logic [2:0]            idx_q, idx_d, fidx_q, fidx_d;
    logic [7:0]            cnt_q, cnt_d, cnt_inc;
    logic [NUM_PERIPH-1:0] en_q, en_d, one_hot;
    logic                  ack_cur;

    assign one_hot = ONE << idx_q;
    assign ack_cur = |(enable_ack & one_hot);
    assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_inc;
        en_d    = en_q;
        fidx_d  = fidx_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (request) begin
                    state_d = START_STEP;
                    idx_d   = '0;
                    en_d    = ONE;
                end
            end
            START_STEP, START_SETTLE: begin
                if (!request) begin
                    // abort: start descending from the highest peripheral already requested
                    state_d = STOP_STEP;
                    en_d    = en_q & ~one_hot;
                    cnt_d   = '0;
                end else if (state_q == START_STEP) begin
                    if (ack_cur) begin
                        state_d = START_SETTLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TO_END) begin
                        state_d = FAULT;
                        en_d    = '0;
                        fidx_d  = idx_q;
                    end
                end else if (cnt_q == SET_END) begin
                    cnt_d = '0;
                    if (idx_q < LAST) begin
                        state_d = START_STEP;
                        idx_d   = idx_q + 3'd1;
                        en_d    = en_q | (one_hot << 1);
                    end else begin
                        state_d = READY;
                    end
                end
            end
            READY: begin
                cnt_d = '0;
                if (!request) begin
                    state_d = STOP_STEP;
                    idx_d   = LAST;
                    en_d    = en_q & ~(ONE << LAST);
                end
            end
            STOP_STEP: begin
                if (!ack_cur) begin
                    state_d = STOP_SETTLE;
                    cnt_d   = '0;
                end else if (cnt_q == TO_END) begin
                    state_d = FAULT;
                    en_d    = '0;
                    fidx_d  = idx_q;
                end
            end
            STOP_SETTLE: begin
                if (cnt_q == SET_END) begin
                    cnt_d = '0;
                    if (idx_q != 3'd0) begin
                        state_d = STOP_STEP;
                        idx_d   = idx_q - 3'd1;
                        en_d    = en_q & ~(one_hot >> 1);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            FAULT: begin
                cnt_d = '0;
                en_d  = '0;
                if (fault_clear && enable_ack == '0) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge async_resetn) begin
        if (!async_resetn) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            en_q    <= '0;
            fidx_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            fidx_q  <= fidx_d;
        end
    end

    assign enable_req  = en_q;
    assign fault_index = fidx_q;
    assign ready       = state_q == READY;
    assign starting    = state_q == START_STEP || state_q == START_SETTLE;
    assign stopping    = state_q == STOP_STEP || state_q == STOP_SETTLE;
    assign fault       = state_q == FAULT;
    assign silent      = state_q == IDLE && enable_ack == '0;
endmodule

// File: tb/tb_peripheral_enable_sequencer.sv
// tb_peripheral_enable_sequencer: directed and random checks of the sequencer against a timeline model.
module tb_peripheral_enable_sequencer;
    localparam int N  = 4;
    localparam int S  = 2;
    localparam int TO = 8;
    localparam int MOFF = 0, MUP = 1, MFULL = 2, MDN = 3, MFLT = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         request = 1'b0;
    logic         fault_clear = 1'b0;
    logic [N-1:0] enable_req, enable_ack = '0, en_prev = '0, stuck0 = '0;
    logic         ready, silent, starting, stopping, fault;
    logic [2:0]   fault_index;

    int tests = 0, fails = 0;
    int now = 0, mode = MOFF, n = 0, t0 = 0, ta = -1, fidx = 0;
    bit rnd = 1'b0;

    peripheral_enable_sequencer #(.NUM_PERIPH(N), .SETTLE_CYCLES(S), .ACK_TIMEOUT(TO)) dut (
        .clock(clk), .async_resetn(rst_n), .request(request), .enable_req(enable_req),
        .enable_ack(enable_ack), .ready(ready), .silent(silent), .starting(starting),
        .stopping(stopping), .fault(fault), .fault_index(fault_index), .fault_clear(fault_clear)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Timeline model: n peripherals on, a step began at t0, its awaited ack was first seen at ta.
    task automatic model();
        now++;
        case (mode)
            MOFF: if (request) begin mode = MUP; n = 1; t0 = now; ta = -1; end
            MUP: begin
                if (!request) begin mode = MDN; n = n - 1; t0 = now; ta = -1; end
                else if (ta < 0 && enable_ack[n-1]) ta = now;
                else if (ta < 0 && now - t0 == TO) begin mode = MFLT; fidx = n - 1; n = 0; end
                else if (ta >= 0 && now - ta == S) begin
                    if (n < N) begin n++; t0 = now; ta = -1; end
                    else mode = MFULL;
                end
            end
            MFULL: if (!request) begin mode = MDN; n = N - 1; t0 = now; ta = -1; end
            MDN: begin
                if (ta < 0 && !enable_ack[n]) ta = now;
                else if (ta < 0 && now - t0 == TO) begin mode = MFLT; fidx = n; n = 0; end
                else if (ta >= 0 && now - ta == S) begin
                    if (n > 0) begin n--; t0 = now; ta = -1; end
                    else mode = MOFF;
                end
            end
            MFLT: if (fault_clear && enable_ack == '0) mode = MOFF;
            default: mode = MOFF;
        endcase
    endtask

    task automatic check_all();
        logic [N-1:0] exp_en;
        exp_en = N'((1 << n) - 1);
        chk("enable_req", 8'(enable_req), 8'(exp_en));
        chk("ready", 8'(ready), 8'(mode == MFULL));
        chk("starting", 8'(starting), 8'(mode == MUP));
        chk("stopping", 8'(stopping), 8'(mode == MDN));
        chk("fault", 8'(fault), 8'(mode == MFLT));
        chk("fault_index", 8'(fault_index), 8'(fidx));
        chk("silent", 8'(silent), 8'(mode == MOFF && enable_ack == '0));
    endtask

    // Each ack moves toward the request seen one cycle earlier, immediately or at random.
    task automatic step();
        @(posedge clk);
        model();
        @(negedge clk);
        check_all();
        for (int k = 0; k < N; k++)
            if (!rnd || $urandom_range(1, 0) == 1) enable_ack[k] = en_prev[k] & ~stuck0[k];
        en_prev = enable_req;
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) step();
    endtask

    initial begin
        #3;
        chk("rst_en", 8'(enable_req), 8'h0);
        chk("rst_ready", 8'(ready), 8'h0);
        chk("rst_starting", 8'(starting), 8'h0);
        chk("rst_stopping", 8'(stopping), 8'h0);
        chk("rst_fault", 8'(fault), 8'h0);
        chk("rst_fidx", 8'(fault_index), 8'h0);
        chk("rst_silent", 8'(silent), 8'h1);
        @(negedge clk);
        rst_n = 1'b1;
        run(2);
        request = 1'b1;
        run(18);
        chk("up_full", 8'(enable_req), 8'hF);
        chk("up_ready", 8'(ready), 8'h1);
        request = 1'b0;
        run(20);
        chk("down_silent", 8'(silent), 8'h1);
        request = 1'b1;
        run(9);
        chk("abort_at_idx2", 8'(enable_req), 8'h7);
        request = 1'b0;
        step();
        chk("abort_first", 8'(enable_req), 8'h3);
        chk("abort_stopping", 8'(stopping), 8'h1);
        run(16);
        chk("abort_idle", 8'(silent), 8'h1);
        request = 1'b1;
        run(18);
        request = 1'b0;
        run(5);
        request = 1'b1;
        run(30);
        chk("restart_ready", 8'(ready), 8'h1);
        request = 1'b0;
        run(20);
        stuck0 = 4'b0010;
        request = 1'b1;
        for (int i = 0; i < 60 && !fault; i++) step();
        chk("timeout_fault", 8'(fault), 8'h1);
        chk("timeout_index", 8'(fault_index), 8'h1);
        chk("timeout_en", 8'(enable_req), 8'h0);
        stuck0 = '0;
        request = 1'b0;
        run(4);
        fault_clear = 1'b1;
        step();
        fault_clear = 1'b0;
        step();
        chk("cleared", 8'(silent), 8'h1);
        request = 1'b1;
        run(6);
        #2 rst_n = 1'b0;
        #1;
        chk("async_en", 8'(enable_req), 8'h0);
        chk("async_starting", 8'(starting), 8'h0);
        chk("async_fidx", 8'(fault_index), 8'h0);
        request = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mode = MOFF; n = 0; fidx = 0; en_prev = '0;
        rnd = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(15, 0) == 0) request = ~request;
            fault_clear = $urandom_range(7, 0) == 0;
            if (i % 150 == 0) stuck0 = ($urandom_range(3, 0) == 0) ? N'(1 << $urandom_range(N - 1, 0)) : '0;
            step();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
